reg_pipe: RTL
=============

# reg_pipe

Parametrised register pipeline: DEPTH stages of WIDTH-bit registers, each stage carrying a valid bit, with a common advance enable, synchronous clear and a registered occupancy count. Successor to the single 4-bit enabled D register; used wherever data must be delayed a fixed number of enabled cycles with stall support (datapath alignment, lab sequencers). Optional per-stage parity detects corruption of stored words.

## Interface
- WIDTH, 4, data width in bits (≥1)
- DEPTH, 4, number of stages (≥1)
- RST_VAL, 0, value loaded into every data stage on reset/clear (WIDTH bits)
- clk  in  1  clock, rising edge active
- reset  in  1  asynchronous, active-low reset
- En  in  1  advance enable; 0 = all stages hold
- clr  in  1  synchronous clear, priority over En
- D  in  WIDTH  input data
- D_vld  in  1  input data valid
- inj  in  1  parity fault inject (used only with REG_PIPE_PARITY_EN)
- Q  out  WIDTH  last-stage data
- Q_vld  out  1  last-stage valid
- fill  out  $clog2(DEPTH+1)  number of valid stages
- full  out  1  fill == DEPTH
- empty  out  1  fill == 0
- parity_err  out  1  parity mismatch on last stage

## Operation
- reset low (any time, mid-operation included): all data stages = RST_VAL, all valid = 0, fill = 0, empty = 1, full = 0, parity_err = 0; stays so until the first rising clk after reset returns high.
- Per rising clk, priority: clr > En > hold.
- clr = 1: all data = RST_VAL, all valid = 0, fill = 0; D/D_vld that cycle discarded.
- En = 1, clr = 0: stage0 <= {D, D_vld}; stage i <= stage i-1 for i = 1..DEPTH-1; old last stage is dropped.
- En = 0, clr = 0: all stages, fill unchanged; D ignored.
- Data shifts regardless of D_vld; invalid words travel as bubbles (Q_vld = 0).
- fill is a registered counter, not a popcount: on En, fill <= fill + D_vld − Q_vld (both 0/1; simultaneous in and out leaves fill unchanged). Never exceeds DEPTH, never below 0.
- full/empty are decoded from registered fill; no extra latency.
- Q, Q_vld driven directly from last-stage flops.
- DEPTH = 1: single stage; fill is 1 bit; Q follows D one enabled cycle later.

## Timing
- Latency: word sampled at edge k with En = 1 appears on Q after edge k+DEPTH−1 if En high on every edge; each En = 0 edge adds one cycle.
- Throughput: one word per enabled edge.
- All outputs registered except parity_err (combinational from last stage).
- Reset assertion is asynchronous; deassertion is sampled by clk; the first edge after deassertion operates normally.

## Configuration
- REG_PIPE_PARITY_EN defined: each stage stores an extra parity bit = ^D ^ inj computed at stage0 capture and shifted with the data; parity_err = Q_vld & (^Q != stored parity). Parity bits reset/clear to ^RST_VAL.
- Not defined: no parity storage; inj ignored; parity_err tied 0.

## Test plan
- Reset: drive reset = 0 mid-stream with fill = 3 -> immediately Q = 0000, Q_vld = 0, fill = 0, empty = 1.
- Fill/flow (WIDTH 4, DEPTH 4): En = 1, D_vld = 1, D = 0001,0010,0011,0100,0101 on 5 edges -> after edge 4 Q = 0001, full = 1; after edge 5 Q = 0010, fill stays 4.
- Stall: after loading 1010, hold En = 0 for 3 edges with D = 0010 -> Q, fill unchanged; En = 1 resumes, 0010 never captured during stall.
- Bubbles: D_vld pattern 1,0,1,0 with En = 1 -> Q_vld toggles 1,0,1,0 from edge 4; fill = 2 steady after edge 4.
- Clear priority: full pipe, clr = 1 and En = 1 with D = 1111, D_vld = 1 -> next edge fill = 0, Q_vld = 0, Q = RST_VAL; 1111 not captured.
- Parity (macro defined): capture D = 0110 with inj = 1, En = 1 -> after DEPTH enabled edges Q = 0110, Q_vld = 1, parity_err = 1; inj = 0 words give parity_err = 0; macro undefined -> parity_err = 0 throughout.

Source files
------------

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage, WIDTH-bit register pipeline with per-stage valid, common advance
// enable, synchronous clear and registered occupancy. Define REG_PIPE_PARITY_EN for per-stage parity.
module reg_pipe #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              FILL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              En,
  input  logic              clr,
  input  logic [WIDTH-1:0]  D,
  input  logic              D_vld,
  input  logic              inj,
  output logic [WIDTH-1:0]  Q,
  output logic              Q_vld,
  output logic [FILL_W-1:0] fill,
  output logic              full,
  output logic              empty,
  output logic              parity_err
);

  function automatic logic f_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [WIDTH-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_nxt;

  // Occupancy tracks entries and exits only; a word entering while another leaves nets zero.
  always_comb begin
    w_fill_nxt = r_fill;
    case ({D_vld, r_vld[DEPTH-1]})
      2'b10:   w_fill_nxt = r_fill + FILL_W'(1);
      2'b01:   w_fill_nxt = r_fill - FILL_W'(1);
      default: w_fill_nxt = r_fill;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= RST_VAL;
      r_vld  <= '0;
      r_fill <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= RST_VAL;
      r_vld  <= '0;
      r_fill <= '0;
    end else if (En) begin
      r_data[0] <= D;
      r_vld[0]  <= D_vld;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      r_fill <= w_fill_nxt;
    end
  end

  assign Q     = r_data[DEPTH-1];
  assign Q_vld = r_vld[DEPTH-1];
  assign fill  = r_fill;
  assign full  = (r_fill == FILL_W'(DEPTH));
  assign empty = (r_fill == '0);

`ifdef REG_PIPE_PARITY_EN
  logic [DEPTH-1:0] r_par;

  // Parity is generated once at capture so corruption anywhere downstream shows at the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par <= {DEPTH{f_parity(RST_VAL)}};
    end else if (clr) begin
      r_par <= {DEPTH{f_parity(RST_VAL)}};
    end else if (En) begin
      r_par[0] <= f_parity(D) ^ inj;
      for (int i = 1; i < DEPTH; i++) r_par[i] <= r_par[i-1];
    end
  end

  assign parity_err = r_vld[DEPTH-1] & (f_parity(r_data[DEPTH-1]) != r_par[DEPTH-1]);
`else
  logic w_unused_inj;
  assign w_unused_inj = inj;
  assign parity_err   = 1'b0;
`endif

endmodule
